// File: rtl/vga_rect_bouncer_if.sv
// rtl/vga_rect_bouncer_if.sv - pixel strobe in, registered VGA signals out; i_pause only with RECT_PAUSE_EN
interface vga_rect_bouncer_if;
  logic       i_pix_stb;
`ifdef RECT_PAUSE_EN
  logic       i_pause;
`endif
  logic       o_hs;
  logic       o_vs;
  logic       o_blank;
  logic       o_frame;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic [7:0] o_rgb;

`ifdef RECT_PAUSE_EN
  modport master (
    output i_pix_stb, i_pause,
    input  o_hs, o_vs, o_blank, o_frame, o_x, o_y, o_rgb
  );
  modport slave (
    input  i_pix_stb, i_pause,
    output o_hs, o_vs, o_blank, o_frame, o_x, o_y, o_rgb
  );
`else
  modport master (
    output i_pix_stb,
    input  o_hs, o_vs, o_blank, o_frame, o_x, o_y, o_rgb
  );
  modport slave (
    input  i_pix_stb,
    output o_hs, o_vs, o_blank, o_frame, o_x, o_y, o_rgb
  );
`endif
endinterface

// File: rtl/vga_rect_bouncer.sv
// rtl/vga_rect_bouncer.sv - VGA timing plus N_RECT bouncing rectangles, RGB332; RECT_PAUSE_EN adds i_pause
module vga_rect_bouncer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int N_RECT   = 4,
  parameter int RECT_W   = 160,
  parameter int RECT_H   = 160,
  parameter int STEP     = 2
) (
  input logic               i_clk,
  input logic               i_rst,
  vga_rect_bouncer_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] W11    = 11'(RECT_W);
  localparam logic [10:0] H11    = 11'(RECT_H);
  localparam logic [10:0] S11    = 11'(STEP);
  localparam logic [9:0]  S10    = 10'(STEP);

  logic [9:0]        h;
  logic [9:0]        v;
  logic [9:0]        rx [N_RECT];
  logic [9:0]        ry [N_RECT];
  logic [N_RECT-1:0] dx_neg;
  logic [N_RECT-1:0] dy_neg;
  logic [9:0]        nxt_rx [N_RECT];
  logic [9:0]        nxt_ry [N_RECT];
  logic [N_RECT-1:0] nxt_dxn;
  logic [N_RECT-1:0] nxt_dyn;
  logic [7:0]        pix_rgb;
  logic              blank_now;
  logic              motion_stb;
  logic              move_en;

  // Start position base+pitch*k, clamped so the rectangle fits in the active area.
  function automatic logic [9:0] init_pos(input int base, input int pitch, input int k, input int lim);
    int p;
    p = base + pitch * k;
    if (p > lim) p = lim;
    return 10'(p);
  endfunction

  // One frame of motion on one axis; returns {negative_direction, position}.
  // The 11-bit sum keeps pos+STEP+size from wrapping near the far edge.
  function automatic logic [10:0] move_axis(input logic [9:0] pos, input logic neg,
                                            input int span, input int size);
    logic [10:0] p11;
    p11 = {1'b0, pos};
    if (!neg) begin
      if (p11 + S11 + 11'(size) > 11'(span)) return {1'b1, 10'(span - size)};
      else                                    return {1'b0, pos + S10};
    end else begin
      if (p11 < S11) return {1'b0, 10'd0};
      else           return {1'b1, pos - S10};
    end
  endfunction

  function automatic logic [7:0] color_of(input int k);
    case (k % 8)
      0:       return 8'hE0;
      1:       return 8'h1C;
      2:       return 8'h03;
      3:       return 8'hFC;
      4:       return 8'hE3;
      5:       return 8'h1F;
      6:       return 8'hFF;
      default: return 8'h92;
    endcase
  endfunction

  assign motion_stb = bus.i_pix_stb && (h == 10'd0) && (v == V_ACT);
`ifdef RECT_PAUSE_EN
  assign move_en = motion_stb && !bus.i_pause;
`else
  assign move_en = motion_stb;
`endif

  // Composite the current pixel; scanning from the top index down lets the lowest hit win.
  always_comb begin
    pix_rgb   = 8'h00;
    blank_now = (h >= H_ACT) || (v >= V_ACT);
    for (int k = N_RECT - 1; k >= 0; k--) begin
      if (({1'b0, h} >= {1'b0, rx[k]}) && ({1'b0, h} < {1'b0, rx[k]} + W11) &&
          ({1'b0, v} >= {1'b0, ry[k]}) && ({1'b0, v} < {1'b0, ry[k]} + H11))
        pix_rgb = color_of(k);
    end
  end

  // Candidate positions/directions for the next motion update.
  always_comb begin
    nxt_dxn = dx_neg;
    nxt_dyn = dy_neg;
    for (int k = 0; k < N_RECT; k++) begin
      {nxt_dxn[k], nxt_rx[k]} = move_axis(rx[k], dx_neg[k], H_ACTIVE, RECT_W);
      {nxt_dyn[k], nxt_ry[k]} = move_axis(ry[k], dy_neg[k], V_ACTIVE, RECT_H);
    end
  end

  // Raster counters, advancing only on the pixel strobe.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      h <= '0;
      v <= '0;
    end else if (bus.i_pix_stb) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Registered outputs, all taken from the pre-increment h/v so they stay aligned.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bus.o_hs    <= 1'b1;
      bus.o_vs    <= 1'b1;
      bus.o_blank <= 1'b0;
      bus.o_frame <= 1'b0;
      bus.o_x     <= '0;
      bus.o_y     <= '0;
      bus.o_rgb   <= '0;
    end else begin
      bus.o_frame <= motion_stb;
      if (bus.i_pix_stb) begin
        bus.o_hs    <= !((h >= HS_BEG) && (h < HS_END));
        bus.o_vs    <= !((v >= VS_BEG) && (v < VS_END));
        bus.o_blank <= blank_now;
        bus.o_x     <= h;
        bus.o_y     <= v;
        bus.o_rgb   <= blank_now ? 8'h00 : pix_rgb;
      end
    end
  end

  // Rectangle state: initial layout on reset, one bounce step per frame.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < N_RECT; k++) begin
        rx[k]     <= init_pos(40, 80, k, H_ACTIVE - RECT_W);
        ry[k]     <= init_pos(40, 60, k, V_ACTIVE - RECT_H);
        dx_neg[k] <= (k % 2) == 1;
      end
      dy_neg <= '0;
    end else if (move_en) begin
      for (int k = 0; k < N_RECT; k++) begin
        rx[k] <= nxt_rx[k];
        ry[k] <= nxt_ry[k];
      end
      dx_neg <= nxt_dxn;
      dy_neg <= nxt_dyn;
    end
  end

endmodule

// File: tb/tb_vga_rect_bouncer.sv
// tb/tb_vga_rect_bouncer.sv - scoreboard bench for vga_rect_bouncer on a reduced raster
module tb_vga_rect_bouncer;

  localparam int HA = 128, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 64,  VFP = 1, VSY = 2, VBP = 1;
  localparam int NR = 3, RW = 16, RH = 9, ST = 5;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int MAXX = HA - RW;
  localparam int MAXY = VA - RH;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic       frame;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] rgb;
  } exp_t;

  logic clk;
  logic rst_n;
  logic stb_q;

  vga_rect_bouncer_if bus();

  vga_rect_bouncer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .N_RECT(NR), .RECT_W(RW), .RECT_H(RH), .STEP(ST)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus(bus)
  );

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         frames_model = 0;
  int         frames_seen = 0;
  int         m_h, m_v;
  int         m_rx[NR], m_ry[NR];
  bit         m_dxn[NR], m_dyn[NR];
  logic [7:0] colours[8] = '{8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'hFF, 8'h92};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0;
    m_v = 0;
    for (int k = 0; k < NR; k++) begin
      m_rx[k]  = (40 + 80 * k > MAXX) ? MAXX : 40 + 80 * k;
      m_ry[k]  = (40 + 60 * k > MAXY) ? MAXY : 40 + 60 * k;
      m_dxn[k] = (k % 2) == 1;
      m_dyn[k] = 1'b0;
    end
  endtask

  // Move by a signed step, then fold back into [0, maxp] and flip direction if clamped.
  task automatic bounce(input int pos, input bit neg, input int maxp, output int npos, output bit nneg);
    int t;
    t    = neg ? pos - ST : pos + ST;
    nneg = neg;
    if (t < 0) begin
      t    = 0;
      nneg = 1'b0;
    end else if (t > maxp) begin
      t    = maxp;
      nneg = 1'b1;
    end
    npos = t;
  endtask

  function automatic logic [7:0] model_colour(input int x, input int y);
    for (int k = 0; k < NR; k++)
      if (x >= m_rx[k] && x < m_rx[k] + RW && y >= m_ry[k] && y < m_ry[k] + RH)
        return colours[k % 8];
    return 8'h00;
  endfunction

  task automatic issue_strobe();
    exp_t e;
    bit   paused;
    e.hs    = !(m_h >= HA + HFP && m_h < HA + HFP + HSY);
    e.vs    = !(m_v >= VA + VFP && m_v < VA + VFP + VSY);
    e.blank = (m_h >= HA) || (m_v >= VA);
    e.frame = (m_h == 0) && (m_v == VA);
    e.x     = 10'(m_h);
    e.y     = 10'(m_v);
    e.rgb   = e.blank ? 8'h00 : model_colour(m_h, m_v);
    paused  = 1'b0;
`ifdef RECT_PAUSE_EN
    bus.i_pause = ($urandom_range(0, 3) == 0);
    paused      = bus.i_pause;
`endif
    if (e.frame) begin
      frames_model++;
      if (!paused)
        for (int k = 0; k < NR; k++) begin
          bounce(m_rx[k], m_dxn[k], MAXX, m_rx[k], m_dxn[k]);
          bounce(m_ry[k], m_dyn[k], MAXY, m_ry[k], m_dyn[k]);
        end
    end
    m_h++;
    if (m_h == HT) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end
    sb.push_back(e);
    bus.i_pix_stb = 1'b1;
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    if ($urandom_range(0, 7) != 0) issue_strobe();
    else                           bus.i_pix_stb = 1'b0;
  endtask

  // Remember whether the DUT saw a strobe on the last edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stb_q <= 1'b0;
    else        stb_q <= bus.i_pix_stb;
  end

  // Monitor: every strobed edge must produce the next expected record.
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (rst_n) begin
      got = {bus.o_hs, bus.o_vs, bus.o_blank, bus.o_frame, bus.o_x, bus.o_y, bus.o_rgb};
      if (stb_q) begin
        if (got.frame) frames_seen++;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("pixel", got, e);
        end
      end else begin
        check("frame_idle", {31'd0, bus.o_frame}, 32'd0);
      end
    end
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int rst_h;
    rst_n         = 1'b0;
    bus.i_pix_stb = 1'b0;
`ifdef RECT_PAUSE_EN
    bus.i_pause   = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.o_hs, bus.o_vs, bus.o_blank, bus.o_frame, bus.o_x, bus.o_y, bus.o_rgb},
          {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0});
    rst_n = 1'b1;

    while (frames_model < 4) drive_cycle();

    rst_h = $urandom_range(0, HT - 1);
    while (!(m_v == 30 && m_h == rst_h)) drive_cycle();
    @(posedge clk);
    #1;
    bus.i_pix_stb = 1'b0;
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_async", {bus.o_hs, bus.o_vs, bus.o_blank, bus.o_frame, bus.o_x, bus.o_y, bus.o_rgb},
          {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    while (!(frames_model == 5 && m_v == 3)) drive_cycle();
    @(posedge clk);
    #1;
    bus.i_pix_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("frame_count", 32'(frames_seen), 32'(frames_model));
    check("sb_final", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
